// File: rtl/isactl_pkg.sv
// Shared state encoding, DSACK size encodings and ISA timing defaults for isactl.
package isactl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    CMD   = 3'd2,
    ACK   = 3'd3,
    RECOV = 3'd4
  } state_t;

  localparam logic [1:0] PORT_NONE = 2'b00;
  localparam logic [1:0] PORT_1    = 2'b01;
  localparam logic [1:0] PORT_2    = 2'b10;

  localparam int DEF_SETUP_CLKS = 2;
  localparam int DEF_CMD8_CLKS  = 12;
  localparam int DEF_CMD16_CLKS = 5;
  localparam int DEF_RECOV_CLKS = 4;

  // Clamp a cycle count into the range the 4-bit state counter can reach.
  function automatic logic [3:0] clk_limit(input int clks);
    logic [3:0] lim;
    if (clks > 32'sd15) begin
      lim = 4'hf;
    end else if (clks < 32'sd0) begin
      lim = 4'h0;
    end else begin
      lim = 4'(clks);
    end
    return lim;
  endfunction

endpackage

// File: rtl/isa_sync.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module isa_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two back-to-back flops; only q may be used by downstream logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b0}};
      q      <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/isactl.sv
// ISA I/O cycle controller: runs a selected CPU bus cycle as a timed ISA I/O
// command (setup, strobe, acknowledge, recovery) with dynamic bus sizing.
module isactl
  import isactl_pkg::*;
#(
  parameter int SETUP_CLKS = DEF_SETUP_CLKS,
  parameter int CMD8_CLKS  = DEF_CMD8_CLKS,
  parameter int CMD16_CLKS = DEF_CMD16_CLKS,
  parameter int RECOV_CLKS = DEF_RECOV_CLKS
) (
  input  logic       CPU_CLK,
  input  logic       RESET,
  input  logic       nISASEL,
  input  logic       nAS,
  input  logic       nDS,
  input  logic       RnW,
  input  logic [1:0] SIZ,
  input  logic       ADDR0,
  input  logic       ISA_IOCHRDY,
  input  logic       ISA_nIOCS16,
  output logic       ISA_nIOR,
  output logic       ISA_nIOW,
  output logic       ISA_nSBHE,
  output logic       ISA_AEN,
  output logic       ISA_RESETDRV,
  output logic       nBUF_LO_EN,
  output logic       nBUF_HI_EN,
  output logic       BUF_DIR,
  output logic [1:0] DSACK
);

  localparam logic [3:0] SETUP_LIM = clk_limit(SETUP_CLKS);
  localparam logic [3:0] CMD8_LIM  = clk_limit(CMD8_CLKS);
  localparam logic [3:0] CMD16_LIM = clk_limit(CMD16_CLKS);
  localparam logic [3:0] RECOV_LIM = clk_limit(RECOV_CLKS);

  state_t     state_r, state_nx;
  logic [3:0] cnt_r, cnt_nx;
  logic [3:0] cmd_lim_s;
  logic       rnw_r, rnw_nx;
  logic [1:0] siz_r, siz_nx;
  logic       addr0_r, addr0_nx;
  logic       port16_r, port16_nx;
  logic       rdy_s;

  logic       owned_nx, cmd_on_nx, sbhe_on_nx;
  logic       nior_r, nior_nx;
  logic       niow_r, niow_nx;
  logic       nsbhe_r, nsbhe_nx;
  logic       aen_r, aen_nx;
  logic       nbuf_lo_r, nbuf_lo_nx;
  logic       nbuf_hi_r, nbuf_hi_nx;
  logic       buf_dir_r, buf_dir_nx;
  logic [1:0] dsack_r, dsack_nx;
  logic       resetdrv_r;

  isa_sync #(.WIDTH(1)) u_rdy_sync (
    .clk (CPU_CLK),
    .rst (RESET),
    .d   (ISA_IOCHRDY),
    .q   (rdy_s)
  );

  assign cmd_lim_s = port16_r ? CMD16_LIM : CMD8_LIM;

  // Next state, transfer attribute capture and Port16 sampling.
  always_comb begin
    state_nx  = state_r;
    rnw_nx    = rnw_r;
    siz_nx    = siz_r;
    addr0_nx  = addr0_r;
    port16_nx = port16_r;
    case (state_r)
      IDLE: begin
        if (!nISASEL && !nAS) begin
          state_nx = SETUP;
          rnw_nx   = RnW;
          siz_nx   = SIZ;
          addr0_nx = ADDR0;
        end else begin
          state_nx = IDLE;
        end
      end
      SETUP: begin
        if (nAS) begin
          state_nx = RECOV;
        end else if (cnt_r >= SETUP_LIM) begin
          state_nx  = CMD;
          port16_nx = ~ISA_nIOCS16;
        end else begin
          state_nx = SETUP;
        end
      end
      CMD: begin
        if (nAS) begin
          state_nx = RECOV;
        end else if ((cnt_r >= cmd_lim_s) && rdy_s) begin
          state_nx = ACK;
        end else begin
          state_nx = CMD;
        end
      end
      ACK: begin
        if (nDS) begin
          state_nx = RECOV;
        end else begin
          state_nx = ACK;
        end
      end
      RECOV: begin
        if (cnt_r >= RECOV_LIM) begin
          state_nx = IDLE;
        end else begin
          state_nx = RECOV;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Cycle counter: reloads on every state change and saturates at 15.
  always_comb begin
    if (state_nx != state_r) begin
      cnt_nx = 4'd1;
    end else if (cnt_r != 4'hf) begin
      cnt_nx = cnt_r + 4'd1;
    end else begin
      cnt_nx = cnt_r;
    end
  end

  // Bus outputs decoded from the state being entered so they register with it.
  always_comb begin
    owned_nx   = (state_nx == SETUP) || (state_nx == CMD) || (state_nx == ACK);
    cmd_on_nx  = (state_nx == CMD) || (state_nx == ACK);
    sbhe_on_nx = addr0_nx || (siz_nx != 2'b01);
    aen_nx     = ~owned_nx;
    buf_dir_nx = owned_nx & rnw_nx;
    nsbhe_nx   = ~(owned_nx & sbhe_on_nx);
    nior_nx    = ~(cmd_on_nx & rnw_nx);
    niow_nx    = ~(cmd_on_nx & ~rnw_nx);
    nbuf_lo_nx = ~(cmd_on_nx & (~port16_nx | ~addr0_nx));
    nbuf_hi_nx = ~(cmd_on_nx & port16_nx & sbhe_on_nx);
    if (state_nx == ACK) begin
      dsack_nx = port16_nx ? PORT_2 : PORT_1;
    end else begin
      dsack_nx = PORT_NONE;
    end
  end

  // State, counter, captured attributes and registered bus outputs.
  always_ff @(posedge CPU_CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      rnw_r      <= 1'b0;
      siz_r      <= 2'b00;
      addr0_r    <= 1'b0;
      port16_r   <= 1'b0;
      nior_r     <= 1'b1;
      niow_r     <= 1'b1;
      nsbhe_r    <= 1'b1;
      aen_r      <= 1'b1;
      nbuf_lo_r  <= 1'b1;
      nbuf_hi_r  <= 1'b1;
      buf_dir_r  <= 1'b0;
      dsack_r    <= PORT_NONE;
      resetdrv_r <= 1'b1;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      rnw_r      <= rnw_nx;
      siz_r      <= siz_nx;
      addr0_r    <= addr0_nx;
      port16_r   <= port16_nx;
      nior_r     <= nior_nx;
      niow_r     <= niow_nx;
      nsbhe_r    <= nsbhe_nx;
      aen_r      <= aen_nx;
      nbuf_lo_r  <= nbuf_lo_nx;
      nbuf_hi_r  <= nbuf_hi_nx;
      buf_dir_r  <= buf_dir_nx;
      dsack_r    <= dsack_nx;
      resetdrv_r <= 1'b0;
    end
  end

  assign ISA_nIOR     = nior_r;
  assign ISA_nIOW     = niow_r;
  assign ISA_nSBHE    = nsbhe_r;
  assign ISA_AEN      = aen_r;
  assign ISA_RESETDRV = resetdrv_r;
  assign nBUF_LO_EN   = nbuf_lo_r;
  assign nBUF_HI_EN   = nbuf_hi_r;
  assign BUF_DIR      = buf_dir_r;
  // Acknowledge falls the instant the CPU releases its data strobe.
  assign DSACK        = dsack_r & {2{~nDS}};

endmodule

// File: tb/tb_isactl.sv
// Bench for isactl: directed scenarios and randomized cycles whose expected
// edge timing is computed from the setup/command/wait/recovery cycle counts.
module tb_isactl;

  localparam int SETUP  = 2;
  localparam int CMD8   = 12;
  localparam int CMD16  = 5;
  localparam int RECOV  = 4;
  localparam int BUDGET = 200;

  logic       CPU_CLK;
  logic       RESET, nISASEL, nAS, nDS, RnW, ADDR0, ISA_IOCHRDY, ISA_nIOCS16;
  logic [1:0] SIZ;
  logic       ISA_nIOR, ISA_nIOW, ISA_nSBHE, ISA_AEN, ISA_RESETDRV;
  logic       nBUF_LO_EN, nBUF_HI_EN, BUF_DIR;
  logic [1:0] DSACK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rise = -100;

  isactl dut (
    .CPU_CLK(CPU_CLK), .RESET(RESET), .nISASEL(nISASEL), .nAS(nAS), .nDS(nDS),
    .RnW(RnW), .SIZ(SIZ), .ADDR0(ADDR0), .ISA_IOCHRDY(ISA_IOCHRDY),
    .ISA_nIOCS16(ISA_nIOCS16), .ISA_nIOR(ISA_nIOR), .ISA_nIOW(ISA_nIOW),
    .ISA_nSBHE(ISA_nSBHE), .ISA_AEN(ISA_AEN), .ISA_RESETDRV(ISA_RESETDRV),
    .nBUF_LO_EN(nBUF_LO_EN), .nBUF_HI_EN(nBUF_HI_EN), .BUF_DIR(BUF_DIR),
    .DSACK(DSACK)
  );

  initial CPU_CLK = 1'b0;
  always #20 CPU_CLK = ~CPU_CLK;
  always @(posedge CPU_CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    nISASEL = 1'b1; nAS = 1'b1; nDS = 1'b1; RnW = 1'b1; SIZ = 2'b00;
    ADDR0 = 1'b0; ISA_IOCHRDY = 1'b1; ISA_nIOCS16 = 1'b1;
  endtask

  task automatic reset_vals(input string tag);
    chk_b({tag, "_nior"}, ISA_nIOR, 1'b1);
    chk_b({tag, "_niow"}, ISA_nIOW, 1'b1);
    chk_b({tag, "_nsbhe"}, ISA_nSBHE, 1'b1);
    chk_b({tag, "_aen"}, ISA_AEN, 1'b1);
    chk_b({tag, "_buflo"}, nBUF_LO_EN, 1'b1);
    chk_b({tag, "_bufhi"}, nBUF_HI_EN, 1'b1);
    chk_b({tag, "_dir"}, BUF_DIR, 1'b0);
    chk_v2({tag, "_dsack"}, DSACK, 2'b00);
    chk_b({tag, "_resetdrv"}, ISA_RESETDRV, 1'b1);
  endtask

  // IOCHRDY level present before edge e: low for lo_len edges from mid-command.
  function automatic logic rdy_val(input int e, input int s, input int lo_len);
    return !((e >= s + SETUP + 2) && (e < s + SETUP + 2 + lo_len));
  endfunction

  task automatic txn(input string tag, input logic rnw, input logic [1:0] siz,
                     input logic addr0, input logic cs16, input int lo_len, input int hold);
    logic p16, sbhe_on, stb_ok, other_ok, stb;
    logic sbhe_setup, sbhe_ack, lo_ack, hi_ack, dir_ack;
    logic [1:0] buf_setup, dsack_at;
    int cmd, s, exp_ack, aen_fall, stb_fall, ack_at, n;
    p16 = !cs16;
    sbhe_on = addr0 || (siz != 2'b01);
    cmd = p16 ? CMD16 : CMD8;
    s = cyc + 1;
    if (last_rise + RECOV + 1 > s) s = last_rise + RECOV + 1;
    exp_ack = s + SETUP + cmd;
    while (!rdy_val(exp_ack - 2, s, lo_len)) exp_ack++;
    RnW = rnw; SIZ = siz; ADDR0 = addr0; ISA_nIOCS16 = cs16;
    nISASEL = 1'b0; nAS = 1'b0; nDS = 1'b0;
    ISA_IOCHRDY = rdy_val(cyc + 1, s, lo_len);
    aen_fall = -1; stb_fall = -1; ack_at = -1; n = 0; stb_ok = 1'b1; other_ok = 1'b1;
    buf_setup = 2'bxx; sbhe_setup = 1'bx; dsack_at = 2'bxx;
    sbhe_ack = 1'bx; lo_ack = 1'bx; hi_ack = 1'bx; dir_ack = 1'bx;
    while (ack_at < 0 && n < BUDGET) begin
      tick();
      n++;
      ISA_IOCHRDY = rdy_val(cyc + 1, s, lo_len);
      stb = rnw ? ISA_nIOR : ISA_nIOW;
      if ((rnw ? ISA_nIOW : ISA_nIOR) == 1'b0) other_ok = 1'b0;
      if (aen_fall < 0 && ISA_AEN == 1'b0) begin
        aen_fall = cyc; buf_setup = {nBUF_LO_EN, nBUF_HI_EN}; sbhe_setup = ISA_nSBHE;
      end
      if (stb_fall < 0) begin
        if (stb == 1'b0) stb_fall = cyc;
      end else if (stb != 1'b0) begin
        stb_ok = 1'b0;
      end
      if (DSACK != 2'b00) begin
        ack_at = cyc; dsack_at = DSACK; sbhe_ack = ISA_nSBHE;
        lo_ack = nBUF_LO_EN; hi_ack = nBUF_HI_EN; dir_ack = BUF_DIR;
      end
    end
    chk_i({tag, "_aen_fall"}, aen_fall, s);
    chk_v2({tag, "_buf_setup"}, buf_setup, 2'b11);
    chk_b({tag, "_sbhe_setup"}, sbhe_setup, !sbhe_on);
    chk_i({tag, "_stb_fall"}, stb_fall, s + SETUP);
    chk_i({tag, "_ack_edge"}, ack_at, exp_ack);
    chk_v2({tag, "_dsack"}, dsack_at, p16 ? 2'b10 : 2'b01);
    chk_b({tag, "_sbhe"}, sbhe_ack, !sbhe_on);
    chk_b({tag, "_buflo"}, lo_ack, !(!p16 || !addr0));
    chk_b({tag, "_bufhi"}, hi_ack, !(p16 && sbhe_on));
    chk_b({tag, "_dir"}, dir_ack, rnw);
    repeat (hold) begin
      tick();
      if ((rnw ? ISA_nIOR : ISA_nIOW) != 1'b0) stb_ok = 1'b0;
    end
    chk_b({tag, "_stb_held"}, stb_ok, 1'b1);
    chk_b({tag, "_other_stb"}, other_ok, 1'b1);
    nDS = 1'b1; nAS = 1'b1; nISASEL = 1'b1; ISA_IOCHRDY = 1'b1;
    #1;
    chk_v2({tag, "_dsack_drop"}, DSACK, 2'b00);
    tick();
    chk_b({tag, "_stb_rise"}, rnw ? ISA_nIOR : ISA_nIOW, 1'b1);
    chk_b({tag, "_aen_rise"}, ISA_AEN, 1'b1);
    chk_v2({tag, "_buf_off"}, {nBUF_LO_EN, nBUF_HI_EN}, 2'b11);
    last_rise = cyc;
  endtask

  task automatic abort_txn(input string tag);
    int s, stb_fall, n;
    logic ds_seen;
    s = cyc + 1;
    if (last_rise + RECOV + 1 > s) s = last_rise + RECOV + 1;
    RnW = 1'b0; SIZ = 2'b01; ADDR0 = 1'b0; ISA_nIOCS16 = 1'b1; ISA_IOCHRDY = 1'b1;
    nISASEL = 1'b0; nAS = 1'b0; nDS = 1'b0;
    stb_fall = -1; n = 0; ds_seen = 1'b0;
    while (stb_fall < 0 && n < BUDGET) begin
      tick();
      n++;
      if (ISA_nIOW == 1'b0) stb_fall = cyc;
      if (DSACK != 2'b00) ds_seen = 1'b1;
    end
    chk_i({tag, "_stb_fall"}, stb_fall, s + SETUP);
    repeat (3) begin
      tick();
      if (DSACK != 2'b00) ds_seen = 1'b1;
    end
    nAS = 1'b1; nISASEL = 1'b1;
    tick();
    chk_b({tag, "_niow"}, ISA_nIOW, 1'b1);
    chk_b({tag, "_aen"}, ISA_AEN, 1'b1);
    chk_b({tag, "_nsbhe"}, ISA_nSBHE, 1'b1);
    chk_v2({tag, "_buf_off"}, {nBUF_LO_EN, nBUF_HI_EN}, 2'b11);
    last_rise = cyc;
    repeat (RECOV) begin
      tick();
      if (DSACK != 2'b00) ds_seen = 1'b1;
    end
    chk_b({tag, "_no_dsack"}, ds_seen, 1'b0);
    nDS = 1'b1;
  endtask

  initial begin
    int n;
    int gap;
    RESET = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset_vals("reset");
    RESET = 1'b0;
    #1;
    chk_b("resetdrv_hold", ISA_RESETDRV, 1'b1);
    tick();
    chk_b("resetdrv_fall", ISA_RESETDRV, 1'b0);
    tick();
    tick();

    txn("byte_rd", 1'b1, 2'b01, 1'b1, 1'b1, 0, 1);
    txn("b2b_rd", 1'b1, 2'b01, 1'b0, 1'b1, 0, 0);
    repeat (3) tick();
    txn("word_wr", 1'b0, 2'b10, 1'b0, 1'b0, 0, 2);
    txn("wait_rd", 1'b1, 2'b01, 1'b0, 1'b1, 20, 0);
    txn("wait16_rd", 1'b1, 2'b10, 1'b0, 1'b0, 6, 1);
    abort_txn("abort");
    txn("post_abort", 1'b1, 2'b01, 1'b1, 1'b0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) tick();
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0,
          int'($urandom_range(0, 3)));
    end

    RnW = 1'b1; SIZ = 2'b01; ADDR0 = 1'b0; ISA_nIOCS16 = 1'b1; ISA_IOCHRDY = 1'b1;
    nISASEL = 1'b0; nAS = 1'b0; nDS = 1'b0;
    n = 0;
    while (DSACK == 2'b00 && n < BUDGET) begin
      tick();
      n++;
    end
    chk_b("rst_reach_ack", DSACK != 2'b00, 1'b1);
    #5 RESET = 1'b1;
    #1 reset_vals("rst_async");
    idle_inputs();
    tick();
    tick();
    RESET = 1'b0;
    #1;
    chk_b("rst2_resetdrv_hold", ISA_RESETDRV, 1'b1);
    tick();
    chk_b("rst2_resetdrv_fall", ISA_RESETDRV, 1'b0);
    last_rise = -100;
    txn("post_reset_rd", 1'b1, 2'b01, 1'b1, 1'b1, 0, 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
